irq_controller: RTL and testbench

- Vectored interrupt controller for the single-cycle 8-bit-PC core.
- Replaces the raw switch-driven interrupt that forces a fixed JAL.
- Collects up to 8 external interrupt sources, synchronises and edge-detects them, holds them pending, and applies a mask and a global enable.
- Dispatches the highest-priority source by injecting one JAL-to-vector instruction in place of the fetched word. Blocks nesting until the handler's return (jr $15) is signalled. Its mask, pending and status registers are memory-mapped alongside the parallel I/O ports.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_sync_edge.sv | 32 +++
 rtl/irq_controller.sv | 196 +++++++++++++++++++
 tb/tb_irq_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

    // Dispatch sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        IN_SVC = 2'd2
    } irq_state_e;

    // Opcode of the jump-and-link instruction injected on dispatch.
    localparam logic [5:0] OP_JAL = 6'b000011;

    // Default bus addresses of the memory-mapped registers.
    localparam logic [7:0] DEF_ADDR_MASK = 8'hF0;
    localparam logic [7:0] DEF_ADDR_PEND = 8'hF1;
    localparam logic [7:0] DEF_ADDR_STAT = 8'hF2;

    // STAT register field positions.
    localparam int unsigned STAT_GIE_BIT = 32'd0;
    localparam int unsigned STAT_SVC_BIT = 32'd1;
    localparam int unsigned STAT_ID_LSB  = 32'd2;
    localparam int unsigned STAT_ID_MSB  = 32'd4;

    // Build the JAL instruction word that jumps to an 8-bit target.
    function automatic logic [31:0] make_jal(input logic [7:0] target);
        return {OP_JAL, 18'd0, target};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser: two metastability flops followed by an edge flop.
// Produces a one-cycle pulse for every synchronised rising edge; a held level
// yields a single pulse.
module irq_sync_edge #(
    parameter int unsigned WIDTH = 32'd4
) (
    input  logic             clk,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] irq_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Two-stage synchroniser plus the history flop used for edge detection.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= irq_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: pending/mask/status registers, fixed
// lowest-index-wins priority, and a three-state sequencer that replaces one
// fetched word with a JAL to the winning source's vector.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ     = 32'd4,
    parameter logic [7:0]  VEC_BASE  = 8'hFA,
    parameter logic [7:0]  ADDR_MASK = DEF_ADDR_MASK,
    parameter logic [7:0]  ADDR_PEND = DEF_ADDR_PEND,
    parameter logic [7:0]  ADDR_STAT = DEF_ADDR_STAT
) (
    input  logic             clk,
    input  logic             iRST_N,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             iret,
    input  logic             bus_we,
    input  logic [7:0]       bus_addr,
    input  logic [7:0]       bus_wdata,
    output logic             bus_sel,
    output logic [7:0]       bus_rdata,
    output logic             int_inject,
    output logic [31:0]      int_inst
);

    irq_state_e       state_r;
    irq_state_e       state_nxt_s;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] pend_r;
    logic [N_IRQ-1:0] pend_nxt_s;
    logic [N_IRQ-1:0] clr_s;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] req_s;
    logic             gie_r;
    logic [2:0]       act_id_r;
    logic [2:0]       act_id_nxt_s;
    logic [2:0]       winner_s;
    logic             dispatch_s;
    logic             int_inject_r;
    logic [31:0]      int_inst_r;
    logic             sel_mask_s;
    logic             sel_pend_s;
    logic             sel_stat_s;
    logic             wr_mask_s;
    logic             wr_pend_s;
    logic             wr_stat_s;
    logic [7:0]       mask_rd_s;
    logic [7:0]       pend_rd_s;
    logic [7:0]       stat_rd_s;
    logic [7:0]       rdata_s;
    logic             unused_wdata_s;

    // Lowest set index of a request vector; 0 when nothing is set.
    function automatic logic [2:0] first_set(input logic [N_IRQ-1:0] req);
        logic [2:0] id;
        id = 3'd0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    irq_sync_edge #(
        .WIDTH (N_IRQ)
    ) u_sync_edge (
        .clk    (clk),
        .iRST_N (iRST_N),
        .irq_in (irq_in),
        .rise   (rise_s)
    );

    // Only the low bits of the write data land in registers.
    assign unused_wdata_s = ^bus_wdata;

    // Address decode and read-data mux for the three mapped registers.
    always_comb begin
        sel_mask_s = (bus_addr == ADDR_MASK);
        sel_pend_s = (bus_addr == ADDR_PEND);
        sel_stat_s = (bus_addr == ADDR_STAT);
        wr_mask_s  = bus_we & sel_mask_s;
        wr_pend_s  = bus_we & sel_pend_s;
        wr_stat_s  = bus_we & sel_stat_s;

        mask_rd_s = 8'd0;
        mask_rd_s[N_IRQ-1:0] = mask_r;
        pend_rd_s = 8'd0;
        pend_rd_s[N_IRQ-1:0] = pend_r;
        stat_rd_s = 8'd0;
        stat_rd_s[STAT_GIE_BIT] = gie_r;
        stat_rd_s[STAT_SVC_BIT] = (state_r == IN_SVC);
        stat_rd_s[STAT_ID_MSB:STAT_ID_LSB] = act_id_r;

        if (sel_mask_s) begin
            rdata_s = mask_rd_s;
        end else if (sel_pend_s) begin
            rdata_s = pend_rd_s;
        end else if (sel_stat_s) begin
            rdata_s = stat_rd_s;
        end else begin
            rdata_s = 8'd0;
        end
    end

    assign bus_sel   = sel_mask_s | sel_pend_s | sel_stat_s;
    assign bus_rdata = rdata_s;

    // Pending update: dispatch and write-1-to-clear remove bits, new edges win.
    always_comb begin
        clr_s = {N_IRQ{1'b0}};
        for (int i = 0; i < int'(N_IRQ); i++) begin
            clr_s[i] = ((state_r == INJECT) && (act_id_r == 3'(i)))
                     | (wr_pend_s & bus_wdata[i]);
        end
        pend_nxt_s = (pend_r & ~clr_s) | rise_s;
        req_s      = pend_r & mask_r;
        winner_s   = first_set(req_s);
    end

    // Sequencer next state; the winner is captured only when leaving IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        dispatch_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (gie_r && (|req_s)) begin
                    state_nxt_s = INJECT;
                    dispatch_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INJECT: begin
                state_nxt_s = IN_SVC;
            end
            IN_SVC: begin
                if (iret) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IN_SVC;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (dispatch_s) begin
            act_id_nxt_s = winner_s;
        end else begin
            act_id_nxt_s = act_id_r;
        end
    end

    // Sequencer state, active id and registered inject outputs.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r      <= IDLE;
            act_id_r     <= 3'd0;
            int_inject_r <= 1'b0;
            int_inst_r   <= make_jal(VEC_BASE);
        end else begin
            state_r      <= state_nxt_s;
            act_id_r     <= act_id_nxt_s;
            int_inject_r <= (state_nxt_s == INJECT);
            int_inst_r   <= make_jal(VEC_BASE + {5'd0, act_id_nxt_s});
        end
    end

    // Software-visible mask, pending and global-enable registers.
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            mask_r <= {N_IRQ{1'b0}};
            pend_r <= {N_IRQ{1'b0}};
            gie_r  <= 1'b0;
        end else begin
            if (wr_mask_s) begin
                mask_r <= bus_wdata[N_IRQ-1:0];
            end else begin
                mask_r <= mask_r;
            end
            pend_r <= pend_nxt_s;
            if (wr_stat_s) begin
                gie_r <= bus_wdata[STAT_GIE_BIT];
            end else begin
                gie_r <= gie_r;
            end
        end
    end

    assign int_inject = int_inject_r;
    assign int_inst   = int_inst_r;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random
// traffic, all compared against a behavioural model of the register rules.
module tb_irq_controller;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq;
    logic        iret;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        bus_sel;
    logic [7:0]  bus_rdata;
    logic        int_inject;
    logic [31:0] int_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase 0 = idle, 1 = injecting, 2 = in service.
    logic [3:0] m_pend, m_mask;
    logic       m_gie;
    int         m_act, m_phase;
    logic [3:0] h0, h1, h2;   // irq samples at the last three edges (h0 newest)

    always #5 clk = ~clk;

    irq_controller #(.N_IRQ(N)) dut (
        .clk        (clk),
        .iRST_N     (rst_n),
        .irq_in     (irq),
        .iret       (iret),
        .bus_we     (we),
        .bus_addr   (addr),
        .bus_wdata  (wdata),
        .bus_sel    (bus_sel),
        .bus_rdata  (bus_rdata),
        .int_inject (int_inject),
        .int_inst   (int_inst)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 4'd0; m_mask = 4'd0; m_gie = 1'b0;
        m_act = 0; m_phase = 0;
        h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
    endtask

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        logic [3:0] set, clr, req;
        int win;
        set = h1 & ~h2;               // a rise becomes pending on the 3rd edge
        clr = 4'd0;
        if (m_phase == 1) clr[m_act] = 1'b1;
        if (we && addr == 8'hF1) clr = clr | wdata[3:0];
        req = m_pend & m_mask;
        win = 0;
        for (int i = 3; i >= 0; i--) if (req[i]) win = i;
        if (m_phase == 0 && m_gie && req != 4'd0) begin
            m_phase = 1; m_act = win;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && iret) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | set;
        if (we && addr == 8'hF0) m_mask = wdata[3:0];
        if (we && addr == 8'hF2) m_gie = wdata[0];
        h2 = h1; h1 = h0; h0 = irq;
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        case (a)
            8'hF0:   return {4'd0, m_mask};
            8'hF1:   return {4'd0, m_pend};
            8'hF2:   return {3'd0, 3'(m_act), (m_phase == 2), m_gie};
            default: return 8'd0;
        endcase
    endfunction

    task automatic check_outputs();
        logic [7:0] vec;
        vec = 8'hFA + 8'(m_act);
        check("inject", {31'd0, int_inject}, {31'd0, (m_phase == 1)});
        check("inst", int_inst, {6'b000011, 18'd0, vec});
        check("sel", {31'd0, bus_sel}, {31'd0, (addr >= 8'hF0 && addr <= 8'hF2)});
        check("rdata", {24'd0, bus_rdata}, {24'd0, exp_rd(addr)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; addr = 8'h00; wdata = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, {24'd0, bus_rdata}, {24'd0, exp});
    endtask

    task automatic pulse_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = 4'd0; iret = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_inject", {31'd0, int_inject}, 32'd0);
        check("rst_inst", int_inst, 32'h0C0000FA);
        rst_n = 1'b1;
        tick();
        rd("rst_mask", 8'hF0, 8'h00);
        rd("rst_pend", 8'hF1, 8'h00);
        rd("rst_stat", 8'hF2, 8'h00);
        addr = 8'hEF; #1; check("sel_EF", {31'd0, bus_sel}, 32'd0);
        addr = 8'hF3; #1; check("sel_F3", {31'd0, bus_sel}, 32'd0);
        addr = 8'hF1; #1; check("sel_F1", {31'd0, bus_sel}, 32'd1);

        // Single source dispatch.
        wr(8'hF0, 8'h0F);
        wr(8'hF2, 8'h01);
        irq = 4'b0100;
        addr = 8'hF1;
        repeat (3) tick();
        rd("pend_after3", 8'hF1, 8'h04);
        tick();
        check("inj_src2", {31'd0, int_inject}, 32'd1);
        check("inst_src2", int_inst, 32'h0C0000FC);
        tick();
        check("inj_1cycle", {31'd0, int_inject}, 32'd0);
        rd("stat_svc2", 8'hF2, 8'h0B);
        rd("pend_clr2", 8'hF1, 8'h00);

        // New edge during service: pending only, dispatched after return.
        irq = 4'b0110;
        repeat (5) tick();
        rd("pend_svc", 8'hF1, 8'h02);
        check("no_inj_svc", {31'd0, int_inject}, 32'd0);
        pulse_iret();
        check("idle_gap", {31'd0, int_inject}, 32'd0);
        tick();
        check("inst_src1", int_inst, 32'h0C0000FB);
        tick();
        pulse_iret();

        // Two simultaneous sources: lowest index first.
        irq = 4'd0;
        repeat (3) tick();
        irq = 4'b1001;
        repeat (4) tick();
        check("inst_src0", int_inst, 32'h0C0000FA);
        tick();
        pulse_iret();
        tick();
        check("inst_src3", int_inst, 32'h0C0000FD);
        tick();
        pulse_iret();

        // Masked source stays pending; W1C; set wins over clear.
        irq = 4'd0;
        repeat (3) tick();
        wr(8'hF0, 8'h0E);
        irq = 4'b0001;
        repeat (3) tick();
        rd("pend_masked", 8'hF1, 8'h01);
        repeat (2) tick();
        wr(8'hF1, 8'h01);
        rd("pend_w1c", 8'hF1, 8'h00);
        irq = 4'd0;
        repeat (2) tick();
        irq = 4'b0001;
        repeat (2) tick();
        wr(8'hF1, 8'h01);
        rd("set_wins", 8'hF1, 8'h01);

        // Async reset while injecting.
        wr(8'hF1, 8'h0F);
        irq = 4'd0;
        wr(8'hF0, 8'h0F);
        irq = 4'b0100;
        repeat (4) tick();
        check("inj_pre_rst", {31'd0, int_inject}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("inj_async_drop", {31'd0, int_inject}, 32'd0);
        model_reset();
        rd("rst2_mask", 8'hF0, 8'h00);
        rd("rst2_stat", 8'hF2, 8'h00);
        rst_n = 1'b1;
        addr = 8'h00;
        repeat (6) tick();
        check("no_retrigger", {31'd0, int_inject}, 32'd0);
        wr(8'hF1, 8'h0F);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            iret = (m_phase != 1) && ($urandom_range(0, 4) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hF0 + 8'($urandom_range(0, 2));
            we = (m_phase != 1) && ($urandom_range(0, 5) == 0);
            wdata = 8'($urandom);
            if (we && addr == 8'hF2 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 check("rnd_rst_inject", {31'd0, int_inject}, 32'd0);
                model_reset();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
